// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready input and a one-cycle done pulse.
// Optional macro PISO_PARITY_EN appends an even-parity bit after the data bits.
module piso_serializer #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned CLK_DIV   = 1,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sdata,
  output logic              sframe,
  output logic              done
);

  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HEAD  = (MSB_FIRST != 0) ? DATA_W - 1 : 0;
  localparam int unsigned NEXT  = (MSB_FIRST != 0) ? DATA_W - 2 : 1;

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  logic parity_q;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t            state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DIV_W-1:0]  div_q;
  logic              sdata_q;
  logic              sframe_q;
  logic              done_q;
  logic              ready_q;

  logic [DATA_W-1:0] shifted_c;
  logic              div_last_c;
  logic              bit_last_c;

  // Shift toward the head so the next bit to send always sits at HEAD
  assign shifted_c  = (MSB_FIRST != 0) ? {shreg_q[DATA_W-2:0], 1'b0}
                                       : {1'b0, shreg_q[DATA_W-1:1]};
  assign div_last_c = (div_q == DIV_W'(CLK_DIV - 1));
  assign bit_last_c = (bit_q == BIT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      sdata_q  <= 1'b1;
      sframe_q <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q  <= SHIFT;
            shreg_q  <= in_data;
            bit_q    <= '0;
            div_q    <= '0;
            sdata_q  <= in_data[HEAD];
            sframe_q <= 1'b1;
            ready_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q <= ^in_data;
`endif
          end
        end
        SHIFT: begin
          if (div_last_c) begin
            div_q <= '0;
            if (bit_last_c) begin
`ifdef PISO_PARITY_EN
              state_q <= PARITY;
              sdata_q <= parity_q;
`else
              state_q  <= IDLE;
              sdata_q  <= 1'b1;
              sframe_q <= 1'b0;
              done_q   <= 1'b1;
              ready_q  <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + BIT_W'(1);
              shreg_q <= shifted_c;
              sdata_q <= shreg_q[NEXT];
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          if (div_last_c) begin
            div_q    <= '0;
            state_q  <= IDLE;
            sdata_q  <= 1'b1;
            sframe_q <= 1'b0;
            done_q   <= 1'b1;
            ready_q  <= 1'b1;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = ready_q;
  assign sdata    = sdata_q;
  assign sframe   = sframe_q;
  assign done     = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer: MSB/LSB order, clock divider,
// back-to-back frames and mid-frame reset; parity expectations follow PISO_PARITY_EN.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_data;
  logic       in_valid;

  logic a_ready, a_sdata, a_sframe, a_done;
  logic b_ready, b_sdata, b_sframe, b_done;
  logic c_ready, c_sdata, c_sframe, c_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.DATA_W(4), .CLK_DIV(1), .MSB_FIRST(1)) dut_a (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(a_ready), .sdata(a_sdata), .sframe(a_sframe), .done(a_done));

  piso_serializer #(.DATA_W(4), .CLK_DIV(1), .MSB_FIRST(0)) dut_b (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(b_ready), .sdata(b_sdata), .sframe(b_sframe), .done(b_done));

  piso_serializer #(.DATA_W(4), .CLK_DIV(3), .MSB_FIRST(1)) dut_c (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(c_ready), .sdata(c_sdata), .sframe(c_sframe), .done(c_done));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [3:0] w1;
  logic [3:0] w2;

  initial begin
    w1 = 4'b1011;
    w2 = 4'b0110;

    // Reset state
    do_reset();
    check_eq("rst_sdata", a_sdata, 1);
    check_eq("rst_sframe", a_sframe, 0);
    check_eq("rst_done", a_done, 0);
    check_eq("rst_ready", a_ready, 1);

    // MSB-first (a) and LSB-first (b), CLK_DIV=1
    in_data = w1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("a_bit", a_sdata, w1[3-i]);
      check_eq("b_bit", b_sdata, w1[i]);
      check_eq("a_sframe", a_sframe, 1);
      check_eq("a_ready_busy", a_ready, 0);
      check_eq("a_done_early", a_done, 0);
      tick();
    end
    if (PAR == 1) begin
      check_eq("a_parity", a_sdata, ^w1);
      check_eq("b_parity", b_sdata, ^w1);
      check_eq("a_par_sframe", a_sframe, 1);
      check_eq("a_par_done", a_done, 0);
      tick();
    end
    check_eq("a_done", a_done, 1);
    check_eq("b_done", b_done, 1);
    check_eq("a_done_sdata", a_sdata, 1);
    check_eq("a_done_sframe", a_sframe, 0);
    check_eq("a_done_ready", a_ready, 1);
    tick();
    check_eq("a_done_once", a_done, 0);

    // CLK_DIV=3 with a mid-frame in_valid pulse that must be ignored
    do_reset();
    in_data = w1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      check_eq("c_bit", c_sdata, w1[3 - c/3]);
      check_eq("c_sframe", c_sframe, 1);
      check_eq("c_ready_busy", c_ready, 0);
      if (c == 4) begin
        in_data = 4'b0000; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    for (int c = 0; c < 3 * PAR; c++) begin
      check_eq("c_parity", c_sdata, ^w1);
      check_eq("c_par_sframe", c_sframe, 1);
      tick();
    end
    check_eq("c_done", c_done, 1);
    check_eq("c_done_sframe", c_sframe, 0);
    tick();
    check_eq("c_no_ghost_frame", c_sframe, 0);
    check_eq("c_idle_sdata", c_sdata, 1);

    // Back-to-back frames with in_valid held high
    do_reset();
    in_data = w1; in_valid = 1'b1;
    tick();
    in_data = w2;
    for (int i = 0; i < 4; i++) begin
      check_eq("bb_bit1", a_sdata, w1[3-i]);
      tick();
    end
    if (PAR == 1) tick();
    check_eq("bb_done1", a_done, 1);
    check_eq("bb_ready1", a_ready, 1);
    check_eq("bb_gap_sframe", a_sframe, 0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("bb_bit2", a_sdata, w2[3-i]);
      check_eq("bb_sframe2", a_sframe, 1);
      tick();
    end
    if (PAR == 1) begin
      check_eq("bb_parity2", a_sdata, ^w2);
      tick();
    end
    check_eq("bb_done2", a_done, 1);

    // Reset during bit 2 aborts the frame without done
    do_reset();
    in_data = w1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check_eq("ab_bit2", a_sdata, w1[2]);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("ab_sdata", a_sdata, 1);
    check_eq("ab_sframe", a_sframe, 0);
    check_eq("ab_ready", a_ready, 1);
    for (int i = 0; i < 8; i++) begin
      check_eq("ab_no_done", a_done, 0);
      check_eq("ab_idle", a_sframe, 0);
      tick();
    end

    // Reset wins over a simultaneous in_valid
    reset = 1'b1; in_data = w1; in_valid = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    check_eq("rp_sframe", a_sframe, 0);
    check_eq("rp_ready", a_ready, 1);
    tick();
    check_eq("rp_sframe_later", a_sframe, 0);
    check_eq("rp_sdata_later", a_sdata, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
